// File: rtl/cpu_seg_top_if.sv
// Pin-side bundle for the seven-segment display top: switch word in,
// active-low segment and digit-select lines out.
interface cpu_seg_top_if;
  logic [15:0] sw;
  logic [7:0]  atog;
  logic [7:0]  seg_cs;

  modport master (output sw, input atog, input seg_cs);
  modport slave  (input sw, output atog, output seg_cs);
endinterface

// File: rtl/cpu_seg_top.sv
// Board display top: synchronised switches and a prescaled tick counter form a
// 32-bit word, scanned one nibble per slot onto an 8-digit common-anode display.
module cpu_seg_top #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned TICK_DIV = 16
) (
  input  logic         clk,
  input  logic         reset,
  cpu_seg_top_if.slave io
);

  localparam int unsigned SW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned TW_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SW_W-1:0] SCAN_LAST = SW_W'(SCAN_DIV - 1);
  localparam logic [TW_W-1:0] TICK_LAST = TW_W'(TICK_DIV - 1);

  logic [15:0]     sync1_q, sync2_q;
  logic [15:0]     tick_q, tick_d;
  logic [TW_W-1:0] tpre_q, tpre_d;
  logic [SW_W-1:0] spre_q, spre_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      atog_q, atog_d;
  logic [7:0]      seg_cs_q, seg_cs_d;
  logic [31:0]     word;
  logic [3:0]      nibble;

  function automatic logic [7:0] seg_encode(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    tpre_d = tpre_q + 1'b1;
    tick_d = tick_q;
    if (tpre_q == TICK_LAST) begin
      tpre_d = '0;
      tick_d = tick_q + 16'd1;
    end

    spre_d = spre_q + 1'b1;
    idx_d  = idx_q;
    if (spre_q == SCAN_LAST) begin
      spre_d = '0;
      idx_d  = idx_q + 3'd1;
    end

    // Outputs are built from the pre-edge index so the first edge after reset
    // release drives digit 0 and each digit holds for exactly SCAN_DIV edges.
    word     = {sync2_q, tick_q};
    nibble   = word[{idx_q, 2'b00} +: 4];
    atog_d   = seg_encode(nibble);
    seg_cs_d = ~(8'b1 << idx_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      tick_q   <= '0;
      tpre_q   <= '0;
      spre_q   <= '0;
      idx_q    <= '0;
      atog_q   <= '1;
      seg_cs_q <= '1;
    end else begin
      sync1_q  <= io.sw;
      sync2_q  <= sync1_q;
      tick_q   <= tick_d;
      tpre_q   <= tpre_d;
      spre_q   <= spre_d;
      idx_q    <= idx_d;
      atog_q   <= atog_d;
      seg_cs_q <= seg_cs_d;
    end
  end

  assign io.atog   = atog_q;
  assign io.seg_cs = seg_cs_q;

endmodule

// File: tb/tb_cpu_seg_top.sv
// Scoreboard bench for cpu_seg_top: default and fastest-divider instances run
// side by side against an edge-count based reference model.
module tb_cpu_seg_top;

  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw = 16'hFCD2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  int unsigned e;
  logic [15:0] h1, h2;

  cpu_seg_top_if ifa ();
  cpu_seg_top_if ifb ();
  assign ifa.sw = sw;
  assign ifb.sw = sw;

  cpu_seg_top #(.SCAN_DIV(4), .TICK_DIV(16)) dut_a (.clk(clk), .reset(reset), .io(ifa));
  cpu_seg_top #(.SCAN_DIV(1), .TICK_DIV(1))  dut_b (.clk(clk), .reset(reset), .io(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected {atog, seg_cs} after the e-th edge since reset release;
  // s is the switch word that was sampled two edges earlier.
  function automatic logic [15:0] model(input int unsigned ed, input int unsigned sd,
                                        input int unsigned td, input logic [15:0] s);
    logic [15:0] tk;
    logic [31:0] w;
    int unsigned idx;
    logic [3:0]  nib;
    tk  = 16'((ed / td) % 65536);
    w   = {s, tk};
    idx = (ed / sd) % 8;
    nib = 4'((w >> (4 * idx)) & 32'hF);
    return {SEG[nib], ~(8'(1) << idx)};
  endfunction

  task automatic step(input logic [15:0] v);
    logic [15:0] s2;
    sw = v;
    @(posedge clk);
    #1;
    s2 = (e >= 2) ? h2 : 16'h0000;
    qa.push_back(model(e, 4, 16, s2));
    qb.push_back(model(e, 1, 1, s2));
    h2 = h1;
    h1 = v;
    e++;
  endtask

  task automatic check_blank(input string tag);
    chk({tag, "_a_atog"}, ifa.atog, 8'hFF);
    chk({tag, "_a_cs"},   ifa.seg_cs, 8'hFF);
    chk({tag, "_b_atog"}, ifb.atog, 8'hFF);
    chk({tag, "_b_cs"},   ifb.seg_cs, 8'hFF);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    e  = 0;
    h1 = 16'h0000;
    h2 = 16'h0000;
  endtask

  always @(negedge clk) begin
    logic [15:0] x;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      chk("a_atog", ifa.atog, x[15:8]);
      chk("a_seg_cs", ifa.seg_cs, x[7:0]);
      chk("a_onehot", 8'($countones(~ifa.seg_cs)), 8'd1);
    end
    if (qb.size() > 0) begin
      x = qb.pop_front();
      chk("b_atog", ifb.atog, x[15:8]);
      chk("b_seg_cs", ifb.seg_cs, x[7:0]);
      chk("b_onehot", 8'($countones(~ifb.seg_cs)), 8'd1);
    end
  end

  initial begin
    int unsigned n;
    int unsigned run;
    logic [15:0] v;

    repeat (1500) begin
      @(negedge clk);
      check_blank("rst_hold");
    end

    release_reset();
    repeat (100) step(16'hFCD2);
    repeat (80)  step(16'h0000);
    run = 0;
    while (run < 400) begin
      v = 16'($urandom);
      n = $urandom_range(1, 12);
      repeat (n) step(v);
      run += n;
    end

    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_blank("async_rst");
    repeat (5) begin
      @(negedge clk);
      check_blank("rst_mid");
    end

    release_reset();
    repeat (65600) step(16'($urandom));

    @(negedge clk);
    #1;
    chk("a_drain", 8'(qa.size()), 8'd0);
    chk("b_drain", 8'(qb.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_seg_top.md
Name: cpu_seg_top

Overview:
- Board-level display top: samples a 16-bit switch word and a free-running tick counter into a 32-bit display word.
- Drives the word onto an 8-digit multiplexed seven-segment display, one digit per scan slot.
- Sits at the FPGA pin boundary: switches in, segment and digit-select lines out.
- Segment and digit-select outputs are active-low (common-anode board).

Parameters:
- SCAN_DIV, 4, clock cycles each digit stays selected (>=1).
- TICK_DIV, 16, clock cycles per increment of the 16-bit tick counter (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw  input  16  switch word, asynchronous to clk.
- atog  output  8  segment lines, active-low; bit0=a … bit6=g, bit7=dp.
- seg_cs  output  8  digit enables, active-low; bit k selects digit k (digit0 rightmost).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Ports are named clk and reset.

Reset (reset=0, takes effect immediately, independent of clk):
- Synchronizer regs=0, tick counter=0, prescalers=0, digit index=0.
- atog=8'hFF and seg_cs=8'hFF (display blank).
- Reset asserted mid-scan blanks the display at once; no other output value is permitted while reset=0.

Switch path:
- sw passes through a 2-flop synchronizer.
- The synced value reaches the display word 2 cycles after sw changes.

Tick counter:
- Prescaler counts 0..TICK_DIV-1.
- On the wrap cycle, the 16-bit tick count increments by 1.
- 16'hFFFF wraps to 16'h0000.

Display word:
- {sw_sync[15:0], tick[15:0]}.
- Digit k shows nibble word[4k+3:4k].

Scan:
- Scan prescaler counts 0..SCAN_DIV-1.
- On its wrap, the digit index increments modulo 8 (7 -> 0).

Outputs (registered, updated every rising edge while reset=1):
- seg_cs = ~(8'b1 << index).
- atog = encode(nibble[index]).
- Exactly one seg_cs bit is low at any time out of reset.

Encoding (dp always 1): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.

Timing after reset release:
- The first rising edge drives digit 0.
- Each digit holds for exactly SCAN_DIV cycles.
- The full frame is 8*SCAN_DIV cycles.
- A nibble change appears on the next edge at which that digit is selected.

Test Plan:
- Hold reset=0 for 1500 cycles with sw=16'hFCD2 -> atog=8'hFF and seg_cs=8'hFF throughout; asserting reset=0 asynchronously mid-cycle blanks both outputs immediately.
- Release reset, sw=16'hFCD2, defaults -> first edge: seg_cs=FE, atog=C0 (tick=0). seg_cs then steps FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles, returning to FE after 32 cycles.
- Same run, digits 4..7 -> atog A4 (2), A1 (d), C6 (C), 8E (F) while seg_cs=EF, DF, BF, 7F respectively.
- Tick count -> increments every 16 cycles; digit 0 reads 1 (atog F9) in the frame after cycle 16. Force-preload tick=16'hFFFF -> wraps to 0000 (digits 0-3 show C0).
- Change sw from FCD2 to 0000 mid-frame -> digits 4-7 show C0 no earlier than 2 cycles later, each at its next selection.
- SCAN_DIV=1, TICK_DIV=1 -> digit advances every cycle; tick increments every cycle; exactly one seg_cs bit low each cycle.
